// File: rtl/counter_pkg.sv
// Shared definitions for the counter preload receiver: ASCII codes,
// byte-receiver state encoding and the bit-period divisor helper.
package counter_pkg;

   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_9  = 8'h39;
   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_t;

   // Number of system clocks per serial bit.
   function automatic int unsigned bit_period(input int unsigned clk_hz,
                                              input int unsigned baud_rate);
      return clk_hz / baud_rate;
   endfunction

endpackage

// File: rtl/counter_preload_rx_if.sv
// Serial line in, decoded preload value and strobes out.
interface counter_preload_rx_if #(
   parameter int unsigned WIDTH = 19
);
   logic             RXD;
   logic [WIDTH-1:0] VALUE;
   logic             LOAD;
   logic             ERR;
   logic             BUSY;

   // Host / board side: drives the line, observes the decoded result.
   modport master (
      output RXD,
      input  VALUE,
      input  LOAD,
      input  ERR,
      input  BUSY
   );

   // Receiver side.
   modport slave (
      input  RXD,
      output VALUE,
      output LOAD,
      output ERR,
      output BUSY
   );
endinterface

// File: rtl/counter_preload_rx_uart.sv
// 8N1 byte receiver: input synchronizer, start-bit qualification,
// mid-bit sampling and stop-bit check. Emits one-cycle byte_valid or
// frame_err strobes the cycle after the stop sample.
module uart_rx_byte
   import counter_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

   logic [1:0] sync;
   logic       rx_s;
   logic       rx_prev;
   logic       fall;

   rx_state_t  state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0] bit_idx, bit_idx_n;
   logic [7:0] shift, shift_n;
   logic       valid_n;
   logic       ferr_n;

   // Two-flop synchronizer plus one delayed copy for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync    <= 2'b11;
         rx_prev <= 1'b1;
      end else begin
         sync    <= {sync[0], rxd};
         rx_prev <= sync[1];
      end
   end

   assign rx_s = sync[1];
   assign fall = rx_prev & ~rx_s;

   // Receiver state, bit timer, bit index, shift register and strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         bit_idx    <= bit_idx_n;
         shift      <= shift_n;
         byte_valid <= valid_n;
         frame_err  <= ferr_n;
      end
   end

   // Next-state logic: half-period start check, full-period data/stop samples.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt + CW'(1);
      bit_idx_n = bit_idx;
      shift_n   = shift;
      valid_n   = 1'b0;
      ferr_n    = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_n = '0;
            if (fall) begin
               state_n = START;
            end
         end
         START: begin
            if (cnt == HALF_LAST) begin
               cnt_n     = '0;
               bit_idx_n = '0;
               // Line back high at mid start bit: glitch, drop silently.
               state_n   = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == FULL_LAST) begin
               cnt_n   = '0;
               shift_n = {rx_s, shift[7:1]};
               if (bit_idx == 3'd7) begin
                  state_n = STOP;
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
               end
            end
         end
         STOP: begin
            if (cnt == FULL_LAST) begin
               cnt_n   = '0;
               state_n = IDLE;
               valid_n = rx_s;
               ferr_n  = ~rx_s;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign rx_byte = shift;

endmodule

// File: rtl/counter_preload_rx.sv
// Decimal-line preload receiver: accumulates ASCII digits from the serial
// byte stream into a WIDTH-bit value and strobes LOAD on a CR/LF, or ERR if
// the line contained a bad byte, a framing error, too many digits or overflow.
module counter_preload_rx
   import counter_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 50000000,
   parameter int unsigned BAUD_RATE  = 9600,
   parameter int unsigned WIDTH      = 19,
   parameter int unsigned MAX_DIGITS = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   counter_preload_rx_if.slave   link
);

   localparam int unsigned N     = bit_period(CLK_HZ, BAUD_RATE);
   localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);
   localparam int unsigned EXT_W = WIDTH + 4;
   localparam logic [EXT_W-1:0] MAX_VAL = {4'b0000, {WIDTH{1'b1}}};

   logic [7:0] rx_byte;
   logic       byte_valid;
   logic       frame_err;

   logic [WIDTH-1:0] acc, acc_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             err, err_n;
   logic [WIDTH-1:0] value_q, value_n;
   logic             load_q, load_n;
   logic             err_pulse, err_pulse_n;

   logic             is_digit;
   logic             is_term;
   logic [3:0]       digit;
   logic [EXT_W-1:0] acc_ext;
   logic [EXT_W-1:0] cand;
   logic             overflow;

   uart_rx_byte #(
      .CLKS_PER_BIT(N)
   ) u_rx (
      .clk       (CLK),
      .rst_n     (RST),
      .rxd       (link.RXD),
      .rx_byte   (rx_byte),
      .byte_valid(byte_valid),
      .frame_err (frame_err)
   );

   assign is_digit = (rx_byte >= ASCII_0) && (rx_byte <= ASCII_9);
   assign is_term  = (rx_byte == ASCII_CR) || (rx_byte == ASCII_LF);
   // For '0'..'9' the low nibble is already the digit value.
   assign digit    = rx_byte[3:0];
   assign acc_ext  = EXT_W'(acc);
   assign cand     = (acc_ext << 3) + (acc_ext << 1) + EXT_W'(digit);
   assign overflow = cand > MAX_VAL;

   // Parser registers and registered output strobes.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         acc       <= '0;
         cnt       <= '0;
         err       <= 1'b0;
         value_q   <= '0;
         load_q    <= 1'b0;
         err_pulse <= 1'b0;
      end else begin
         acc       <= acc_n;
         cnt       <= cnt_n;
         err       <= err_n;
         value_q   <= value_n;
         load_q    <= load_n;
         err_pulse <= err_pulse_n;
      end
   end

   // Line parser: digits accumulate, terminators resolve, anything else poisons the line.
   always_comb begin
      acc_n       = acc;
      cnt_n       = cnt;
      err_n       = err;
      value_n     = value_q;
      load_n      = 1'b0;
      err_pulse_n = 1'b0;
      if (frame_err) begin
         err_n = 1'b1;
      end else if (byte_valid) begin
         if (is_digit) begin
            if (!err) begin
               if ((cnt == CNT_W'(MAX_DIGITS)) || overflow) begin
                  err_n = 1'b1;
               end else begin
                  acc_n = cand[WIDTH-1:0];
                  cnt_n = cnt + CNT_W'(1);
               end
            end
         end else if (is_term) begin
            if (err) begin
               err_pulse_n = 1'b1;
            end else if (cnt != '0) begin
               value_n = acc;
               load_n  = 1'b1;
            end
            acc_n = '0;
            cnt_n = '0;
            err_n = 1'b0;
         end else begin
            err_n = 1'b1;
         end
      end
   end

   assign link.VALUE = value_q;
   assign link.LOAD  = load_q;
   assign link.ERR   = err_pulse;
   assign link.BUSY  = (cnt != '0) || err;

endmodule

// File: tb/tb_counter_preload_rx.sv
// Randomized self-checking bench for counter_preload_rx with a line-level
// reference model of the decimal preload protocol.
module tb_counter_preload_rx;

   localparam int unsigned N          = 16;
   localparam int unsigned WIDTH      = 19;
   localparam int unsigned MAX_DIGITS = 6;
   localparam longint unsigned MAX_VAL = (64'd1 << WIDTH) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   counter_preload_rx_if #(.WIDTH(WIDTH)) link ();

   counter_preload_rx #(
      .CLK_HZ    (16),
      .BAUD_RATE (1),
      .WIDTH     (WIDTH),
      .MAX_DIGITS(MAX_DIGITS)
   ) dut (
      .CLK (clk),
      .RST (rst_n),
      .link(link)
   );

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model state (line level).
   longint unsigned m_acc = 0;
   int unsigned     m_cnt = 0;
   bit              m_err = 0;
   longint unsigned exp_loads[$];
   int unsigned     exp_errs = 0;
   longint unsigned exp_value = 0;

   // Observed events.
   longint unsigned got_loads[$];
   int unsigned     got_errs = 0;
   logic            load_d = 1'b0;
   logic            errp_d = 1'b0;
   logic            rst_d = 1'b0;
   logic [WIDTH-1:0] value_d = '0;

   // Monitor on the inactive edge: collect strobes, check pulse widths and VALUE stability.
   always @(negedge clk) begin
      if (rst_n && rst_d) begin
         if (link.LOAD) begin
            got_loads.push_back(longint'(link.VALUE));
            check_eq("load_width", load_d, 0);
         end
         if (link.ERR) begin
            got_errs++;
            check_eq("err_width", errp_d, 0);
         end
         if (!link.LOAD && (link.VALUE !== value_d))
            check_eq("value_hold", link.VALUE, value_d);
      end
      load_d  = link.LOAD;
      errp_d  = link.ERR;
      value_d = link.VALUE;
      rst_d   = rst_n;
   end

   task automatic model_clear();
      m_acc = 0;
      m_cnt = 0;
      m_err = 0;
   endtask

   task automatic model_byte(input logic [7:0] b, input bit frame_ok);
      longint unsigned next;
      if (!frame_ok) begin
         m_err = 1;
      end else if (b >= 8'h30 && b <= 8'h39) begin
         if (!m_err) begin
            next = m_acc * 10 + longint'(b - 8'h30);
            if (m_cnt == MAX_DIGITS || next > MAX_VAL) m_err = 1;
            else begin
               m_acc = next;
               m_cnt++;
            end
         end
      end else if (b == 8'h0D || b == 8'h0A) begin
         if (m_err) exp_errs++;
         else if (m_cnt > 0) begin
            exp_loads.push_back(m_acc);
            exp_value = m_acc;
         end
         model_clear();
      end else begin
         m_err = 1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop_ok);
      model_byte(b, stop_ok);
      link.RXD = 1'b0;
      repeat (N) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         link.RXD = b[i];
         repeat (N) @(negedge clk);
      end
      link.RXD = stop_ok;
      repeat (N) @(negedge clk);
      link.RXD = 1'b1;
      if (!stop_ok) repeat (N) @(negedge clk);
      else repeat ($urandom_range(0, N - 1)) @(negedge clk);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
   endtask

   task automatic verify(input string tag);
      int unsigned n;
      repeat (6) @(negedge clk);
      #1;
      check_eq({tag, ":loads"}, got_loads.size(), exp_loads.size());
      n = (got_loads.size() < exp_loads.size()) ? got_loads.size() : exp_loads.size();
      for (int i = 0; i < n; i++)
         check_eq({tag, ":load_value"}, got_loads[i], exp_loads[i]);
      check_eq({tag, ":errs"}, got_errs, exp_errs);
      check_eq({tag, ":value"}, link.VALUE, exp_value);
      check_eq({tag, ":busy"}, link.BUSY, (m_cnt > 0) || m_err);
      got_loads.delete();
      exp_loads.delete();
      got_errs = 0;
      exp_errs = 0;
   endtask

   initial begin
      logic [7:0] ch5;
      logic [7:0] c;
      int unsigned len;
      int unsigned r;

      link.RXD = 1'b1;
      rst_n = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      check_eq("rst:value", link.VALUE, 0);
      check_eq("rst:load", link.LOAD, 0);
      check_eq("rst:err", link.ERR, 0);
      check_eq("rst:busy", link.BUSY, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      send_str("1234\r");                verify("l1234");
      send_str("524287\r\n");            verify("max");
      send_str("524288\r");              verify("over");
      send_str("0000001\r");             verify("seven_digits");
      send_str("7\n");                   verify("seven");
      send_str("12a3\r");                verify("bad_char");
      send_str("\r");                    verify("blank");

      send_byte(8'h35, 1'b0);
      send_str("6\r");                   verify("frame_err");
      send_str("9\r");                   verify("nine");

      // Short low glitch must not produce a byte.
      link.RXD = 1'b0;
      repeat (4) @(negedge clk);
      link.RXD = 1'b1;
      repeat (40) @(negedge clk);
      verify("glitch");
      send_str("3\r");                   verify("after_glitch");

      // Reset during bit 3 of the second digit of "45\r".
      send_byte(8'h34, 1'b1);
      ch5 = 8'h35;
      link.RXD = 1'b0;
      repeat (N) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         link.RXD = ch5[i];
         repeat (N) @(negedge clk);
      end
      link.RXD = ch5[3];
      repeat (N / 2) @(negedge clk);
      #1;
      check_eq("pre_rst:busy", link.BUSY, (m_cnt > 0) || m_err);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst:value", link.VALUE, 0);
      check_eq("mid_rst:load", link.LOAD, 0);
      check_eq("mid_rst:err", link.ERR, 0);
      check_eq("mid_rst:busy", link.BUSY, 0);
      model_clear();
      exp_value = 0;
      exp_loads.delete();
      exp_errs = 0;
      got_loads.delete();
      got_errs = 0;
      repeat (3) @(negedge clk);
      link.RXD = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      send_str("8\r");                   verify("after_rst");

      // Random lines: mostly digits, occasional letters and framing errors.
      for (int k = 0; k < 15; k++) begin
         len = $urandom_range(0, 8);
         for (int j = 0; j < len; j++) begin
            r = $urandom_range(0, 99);
            if (r < 86) begin
               c = 8'h30 + 8'($urandom_range(0, 9));
               send_byte(c, 1'b1);
            end else if (r < 93) begin
               c = 8'h61 + 8'($urandom_range(0, 25));
               send_byte(c, 1'b1);
            end else begin
               c = 8'h30 + 8'($urandom_range(0, 9));
               send_byte(c, 1'b0);
            end
         end
         send_byte(($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A, 1'b1);
         verify("random");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
